// File: rtl/multi_triangle_renderer.sv
// multi_triangle_renderer: raster timing generator that fills up to NUM_TRI double-buffered triangles over a background
module multi_triangle_renderer #(
  parameter int H_ACTIVE_VIDEO = 1280,
  parameter int H_FRONT_PORCH  = 110,
  parameter int H_SYNC_WIDTH   = 40,
  parameter int H_BACK_PORCH   = 220,
  parameter int V_ACTIVE_VIDEO = 720,
  parameter int V_FRONT_PORCH  = 5,
  parameter int V_SYNC_WIDTH   = 5,
  parameter int V_BACK_PORCH   = 20,
  parameter int NUM_TRI        = 4,
  parameter int COORD_W        = 12,
  parameter int PIPE_LAT       = 3
) (
  input  logic                                          pixel_clk,
  input  logic                                          rst,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [(NUM_TRI > 1 ? $clog2(NUM_TRI) : 1)-1:0] cfg_idx,
  input  logic [6*COORD_W-1:0]                          cfg_vtx,
  input  logic [23:0]                                   cfg_color,
  input  logic                                          cfg_en,
  input  logic [23:0]                                   bg_color,
  output logic                                          frame_start,
  output logic [23:0]                                   video_out_pData,
  output logic                                          video_out_pHSync,
  output logic                                          video_out_pVSync,
  output logic                                          video_out_pVDE
);
  localparam int H_FRAME = H_ACTIVE_VIDEO + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int V_FRAME = V_ACTIVE_VIDEO + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int XW = $clog2(H_FRAME);
  localparam int YW = $clog2(V_FRAME);
  localparam int EW = 2*COORD_W + 4;
  localparam int HS0 = H_ACTIVE_VIDEO + H_FRONT_PORCH;
  localparam int VS0 = V_ACTIVE_VIDEO + V_FRONT_PORCH;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic x_last, commit;
  logic [6*COORD_W-1:0] sh_vtx_q [NUM_TRI];
  logic [6*COORD_W-1:0] act_vtx_q [NUM_TRI];
  logic [23:0] sh_col_q [NUM_TRI];
  logic [23:0] act_col_q [NUM_TRI];
  logic [NUM_TRI-1:0] sh_en_q, act_en_q;
  logic signed [EW-1:0] px, py;
  logic signed [EW-1:0] e_d [NUM_TRI][3];
  logic signed [EW-1:0] e_q [NUM_TRI][3];
  logic [23:0] col_q [NUM_TRI];
  logic [NUM_TRI-1:0] en_q;
  logic [3:0] fl_d, fl_q;
  logic [23:0] c;
  logic [27:0] pipe_d;
  logic [27:0] pipe_q [PIPE_LAT-1];

  function automatic logic signed [EW-1:0] ext(input logic [COORD_W-1:0] v);
    return $signed({{(EW-COORD_W){1'b0}}, v});
  endfunction

  // Edge k runs from vertex k to vertex (k+1)%3; the result is the signed cross product
  function automatic logic signed [EW-1:0] edge_fn(input logic [6*COORD_W-1:0] v, input int k,
                                                   input logic signed [EW-1:0] qx, input logic signed [EW-1:0] qy);
    int j;
    logic signed [EW-1:0] xa, ya, xb, yb;
    j = (k + 1) % 3;
    xa = ext(v[2*k*COORD_W +: COORD_W]);
    ya = ext(v[(2*k+1)*COORD_W +: COORD_W]);
    xb = ext(v[2*j*COORD_W +: COORD_W]);
    yb = ext(v[(2*j+1)*COORD_W +: COORD_W]);
    return (xb - xa) * (qy - ya) - (yb - ya) * (qx - xa);
  endfunction

  // Same sign on all three edges covers both windings; a zero-area triangle only passes where all are zero
  function automatic logic is_in(input logic signed [EW-1:0] e0, input logic signed [EW-1:0] e1,
                                 input logic signed [EW-1:0] e2);
    return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction

  assign x_last    = x_q == XW'(H_FRAME - 1);
  assign commit    = x_last && y_q == YW'(V_FRAME - 1);
  assign cfg_ready = !rst && !commit;
  assign x_d       = x_last ? '0 : x_q + XW'(1);
  assign y_d       = !x_last ? y_q : commit ? '0 : y_q + YW'(1);
  assign {frame_start, video_out_pVSync, video_out_pHSync, video_out_pVDE, video_out_pData} = pipe_q[PIPE_LAT-2];

  // Raster position counters
  always_ff @(posedge pixel_clk)
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end

  // Shadow bank takes writes; the whole bank moves to the active bank on the last pixel of the frame
  always_ff @(posedge pixel_clk)
    if (rst) begin
      sh_vtx_q  <= '{default: '0};
      sh_col_q  <= '{default: '0};
      sh_en_q   <= '0;
      act_vtx_q <= '{default: '0};
      act_col_q <= '{default: '0};
      act_en_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_TRI; i++)
        if (cfg_valid && cfg_ready && int'(cfg_idx) == i) begin
          sh_vtx_q[i] <= cfg_vtx;
          sh_col_q[i] <= cfg_color;
          sh_en_q[i]  <= cfg_en;
        end
      if (commit) begin
        act_vtx_q <= sh_vtx_q;
        act_col_q <= sh_col_q;
        act_en_q  <= sh_en_q;
      end
    end

  // Edge functions of the current pixel against every active slot, plus raw timing flags
  always_comb begin
    px = $signed({{(EW-XW){1'b0}}, x_q});
    py = $signed({{(EW-YW){1'b0}}, y_q});
    for (int i = 0; i < NUM_TRI; i++)
      for (int k = 0; k < 3; k++)
        e_d[i][k] = edge_fn(act_vtx_q[i], k, px, py);
    fl_d = {x_q == '0 && y_q == '0,
            y_q >= YW'(VS0) && y_q < YW'(VS0 + V_SYNC_WIDTH),
            x_q >= XW'(HS0) && x_q < XW'(HS0 + H_SYNC_WIDTH),
            x_q < XW'(H_ACTIVE_VIDEO) && y_q < YW'(V_ACTIVE_VIDEO)};
  end

  // Stage 1 captures edge results with the slot colours they belong to, so a commit cannot tear in-flight pixels
  always_ff @(posedge pixel_clk)
    if (rst) begin
      e_q   <= '{default: '0};
      col_q <= '{default: '0};
      en_q  <= '0;
      fl_q  <= '0;
    end else begin
      e_q   <= e_d;
      col_q <= act_col_q;
      en_q  <= act_en_q;
      fl_q  <= fl_d;
    end

  // Lowest-index covering slot wins; output byte order is {R,B,G} and blanked outside the active area
  always_comb begin
    c = bg_color;
    for (int i = NUM_TRI - 1; i >= 0; i--)
      c = en_q[i] && is_in(e_q[i][0], e_q[i][1], e_q[i][2]) ? col_q[i] : c;
    pipe_d = {fl_q, fl_q[0] ? {c[23:16], c[7:0], c[15:8]} : 24'h0};
  end

  // Delay line padding the total latency to PIPE_LAT; its last entry drives the outputs
  always_ff @(posedge pixel_clk)
    if (rst) pipe_q <= '{default: '0};
    else begin
      pipe_q[0] <= pipe_d;
      for (int i = 1; i < PIPE_LAT - 1; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
endmodule
